// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU definitions.
//   fcmp_op_t   compare/select opcode encoding (values 5..7 are reserved)
//   EXP_ZERO    exponent field value that marks an operand as zero
//   field slice positions for IEEE-754 single precision
//   fp_is_zero  exponent-zero test (flush-to-zero rule)
package fpu_pkg;

    typedef enum logic [2:0] {
        FEQ  = 3'd0,
        FLT  = 3'd1,
        FLE  = 3'd2,
        FMIN = 3'd3,
        FMAX = 3'd4
    } fcmp_op_t;

    localparam logic [7:0] EXP_ZERO = 8'd0;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAG_MSB  = 30;

    // Denormals and signed zeros all count as zero.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return x[EXP_MSB:EXP_LSB] == EXP_ZERO;
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// fcmp_core: combinational single-precision compare.
//   x1, x2  in  32  operands
//   lt      out 1   x1 < x2 (flush-to-zero, no NaN handling)
//   eq      out 1   both zero, or bitwise identical
module fcmp_core
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        lt,
    output logic        eq
);

    logic        w_s1;
    logic        w_s2;
    logic [30:0] w_em1;
    logic [30:0] w_em2;
    logic        w_both_zero;

    assign w_s1        = x1[SIGN_BIT];
    assign w_s2        = x2[SIGN_BIT];
    assign w_em1       = x1[MAG_MSB:0];
    assign w_em2       = x2[MAG_MSB:0];
    assign w_both_zero = fp_is_zero(x1) & fp_is_zero(x2);

    // Sign-magnitude ordering on {exp,mant}; exponent 255 is just a big magnitude.
    assign lt = ~w_both_zero &
                ((w_s1 & ~w_s2) |
                 (w_s1 &  w_s2 & (w_em1 > w_em2)) |
                 (~w_s1 & ~w_s2 & (w_em1 < w_em2)));

    assign eq = w_both_zero | (x1 == x2);

endmodule

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage valid/ready FP compare/select unit.
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    request handshake; op, x1, x2 request payload
//   out_valid/out_ready  result handshake; y result
// S1 holds op/operands plus lt/eq; S2 holds the selected result.
module fcmp_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    logic        r_s1_valid;
    logic [2:0]  r_s1_op;
    logic [31:0] r_s1_x1;
    logic [31:0] r_s1_x2;
    logic        r_s1_lt;
    logic        r_s1_eq;
    logic        r_s2_valid;
    logic [31:0] r_y;

    logic        w_lt;
    logic        w_eq;
    logic        w_s1_adv;
    logic        w_s2_adv;
    logic [31:0] w_y_sel;

    fcmp_core u_core (
        .x1 (x1),
        .x2 (x2),
        .lt (w_lt),
        .eq (w_eq)
    );

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_s2_adv  = ~r_s2_valid | out_ready;
    assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign y         = r_y;

    always_comb begin
        w_y_sel = '0;
        case (r_s1_op)
            FEQ:     w_y_sel = {31'b0, r_s1_eq};
            FLT:     w_y_sel = {31'b0, r_s1_lt};
            FLE:     w_y_sel = {31'b0, r_s1_lt | r_s1_eq};
            // Ties (incl. +0/-0) return x1 for both MIN and MAX.
            FMIN:    w_y_sel = (r_s1_lt | r_s1_eq) ? r_s1_x1 : r_s1_x2;
            FMAX:    w_y_sel = r_s1_lt ? r_s1_x2 : r_s1_x1;
            default: w_y_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_x1    <= '0;
            r_s1_x2    <= '0;
            r_s1_lt    <= 1'b0;
            r_s1_eq    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            // Payload only captured on a real request so idle inputs don't toggle S1.
            if (in_valid) begin
                r_s1_op <= op;
                r_s1_x1 <= x1;
                r_s1_x2 <= x2;
                r_s1_lt <= w_lt;
                r_s1_eq <= w_eq;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid)
                r_y <= w_y_sel;
        end
    end

endmodule

// File: tb/tb_fcmp_pipe.sv
module tb_fcmp_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;
    int max_run  = 0;
    bit prev_xfer = 1'b0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fcmp_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Reference: map each operand onto a signed integer number line.
    // Flushed zeros all land on 0; otherwise sign-magnitude -> signed value.
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        if (x[30:23] == 8'd0) return 0;
        m = longint'({33'b0, x[30:0]});
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint ka = fkey(a);
        longint kb = fkey(b);
        case (o)
            3'd0:    return {31'b0, ka == kb};
            3'd1:    return {31'b0, ka < kb};
            3'd2:    return {31'b0, ka <= kb};
            3'd3:    return (ka <= kb) ? a : b;
            3'd4:    return (ka < kb) ? b : a;
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard monitor: the head entry must be on y whenever out_valid is up,
    // which also proves y holds steady through a stall.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", y, 32'hxxxxxxxx);
            end else begin
                chk("result", y, sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (!rst && out_valid && out_ready) begin
            run_len = prev_xfer ? run_len + 1 : 1;
            if (run_len > max_run) max_run = run_len;
            prev_xfer = 1'b1;
        end else begin
            prev_xfer = 1'b0;
        end
    end

    task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit rnd_bp);
        bit done = 1'b0;
        op = o; x1 = a; x2 = b; in_valid = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(o, a, b));
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 2) != 0);
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=in_ready_low expected=accept");
        end
        in_valid = 1'b0;
        op = $urandom(); x1 = $urandom(); x2 = $urandom();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("drain_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] pool [6] = '{32'h00000000, 32'h80000000, 32'h3F800000,
                                  32'hBF800000, 32'h7F800000, 32'hFF800001};
        logic [31:0] v = $urandom();
        case ($urandom_range(0, 5))
            0:       return {v[31], 8'h00, v[22:0]};
            1:       return pool[$urandom_range(0, 5)];
            2:       return {v[31], 8'hFF, v[22:0]};
            default: return v;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y", y, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", in_ready, 1);

        // Latency: empty pipe, result visible two cycles after the accept cycle.
        send(3'd1, 32'h3F800000, 32'h40000000, 0);
        @(negedge clk); chk("lat_cyc1_out_valid", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("lat_cyc2_out_valid", out_valid, 1);
        @(posedge clk); #1;
        drain();

        send(3'd1, 32'h40000000, 32'h3F800000, 0); drain();
        send(3'd2, 32'h3F800000, 32'h3F800000, 0); drain();
        send(3'd1, 32'hBF800000, 32'h3F800000, 0); drain();
        send(3'd1, 32'hC0000000, 32'hBF800000, 0); drain();
        send(3'd4, 32'hBF800000, 32'hC0000000, 0); drain();
        send(3'd0, 32'h80000000, 32'h00000000, 0); drain();
        send(3'd1, 32'h80000000, 32'h00000000, 0); drain();
        send(3'd0, 32'h00000001, 32'h00000000, 0); drain();
        send(3'd3, 32'h80000000, 32'h00000000, 0); drain();
        send(3'd4, 32'h00000000, 32'h80000000, 0); drain();

        // Back-to-back burst: 8 results on 8 consecutive cycles.
        max_run = 0;
        for (int i = 0; i < 8; i++) send(3'(i % 5), rnd_fp(), rnd_fp(), 0);
        drain();
        chk("burst_consecutive", max_run, 8);

        // Backpressure: two accepted, third held off while out_ready=0.
        out_ready = 1'b0;
        send(3'd3, 32'h40400000, 32'h3F800000, 0);
        send(3'd1, 32'hBF800000, 32'h00000000, 0);
        op = 3'd4; x1 = 32'h3F800000; x2 = 32'h40800000; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(3'd4, 32'h3F800000, 32'h40800000, 0);
        drain();

        // Reset with two in flight.
        send(3'd0, 32'h12345678, 32'h12345678, 0);
        send(3'd2, 32'hC1000000, 32'h41000000, 0);
        #2 rst = 1'b1;
        #1 chk("rst_async_out_valid", out_valid, 0);
        sb.delete();
        @(posedge clk); #1;
        chk("rst_held_y", y, 0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;

        // Reserved opcodes still handshake and return 0.
        send(3'd6, 32'h3F800000, 32'h40000000, 0);
        send(3'd5, 32'hBF800000, 32'h00000000, 0);
        send(3'd7, $urandom(), $urandom(), 0);
        drain();

        // Random traffic with random backpressure and idle gaps.
        for (int i = 0; i < 300; i++) begin
            a = rnd_fp();
            b = ($urandom_range(0, 7) == 0) ? a : rnd_fp();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 2) != 0);
            end
            send(3'($urandom_range(0, 7)), a, b, 1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
